angle_modulate_ms: RTL and testbench

- Parametrised multi-mode angle modulator (FM / PM / CW): the successor to the fixed 12-bit FM DDS in the DSP/Communicate/Modulate tree.
- Accepts a strobed signed baseband sample stream and atomically loaded carrier/deviation configuration.
- Produces a signed sine carrier through a quarter-wave ROM of parametrised depth, with output-valid tracking and phase-accumulator clear.
- Sits between the baseband source (ADC/NCO/test pattern) and the DAC interface.

---
 rtl/angle_modulate_ms.sv | 165 ++++++++++++++++
 tb/tb_angle_modulate_ms.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/angle_modulate_ms.sv
// angle_modulate_ms: multi-mode (FM / PM / CW) angle modulator.
// A strobed, sample-and-hold baseband stream is scaled by the deviation word.
// The result either steers the tuning word (FM) or is added straight to the
// phase (PM). The phase addresses a quarter-wave sine ROM, and the output is a
// signed carrier. The pipeline runs S0 hold, S1 product, S2 tuning word,
// S3 accumulator, S4 phase, S5 ROM and S6 sign, so a strobed sample reaches
// wave_out six enabled edges later.
//
// Interface handshake: in_valid is a one-way strobe with no ready. wave_in is
// captured into the hold register on every edge where in_valid is high,
// whether or not en is high. Between strobes the last captured sample is
// reused. cfg_load is a one-cycle pulse that copies every cfg_* input into the
// shadow configuration at that edge. The new values take effect on the
// following edge.
module angle_modulate_ms #(
  parameter int INPUT_WIDTH  = 12,
  parameter int PHASE_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 12,
  parameter int LUT_AW       = 8,
  parameter int PM_SHIFT     = 0
) (
  input  logic                               clk,
  input  logic                               RST,
  input  logic                               en,
  input  logic                               in_valid,
  input  logic [INPUT_WIDTH-1:0]             wave_in,
  input  logic                               cfg_load,
  input  logic [1:0]                         cfg_mode,
  input  logic [PHASE_WIDTH-1:0]             cfg_center,
  input  logic [PHASE_WIDTH-INPUT_WIDTH-1:0] cfg_dev,
  input  logic [PHASE_WIDTH-1:0]             cfg_phase_off,
  input  logic                               phase_clr,
  output logic [OUTPUT_WIDTH-1:0]            wave_out,
  output logic                               out_valid
);

  localparam int DEV_W     = PHASE_WIDTH - INPUT_WIDTH;
  localparam int MAG_W     = OUTPUT_WIDTH - 1;
  localparam int ROM_DEPTH = 1 << LUT_AW;
  localparam int AMP       = (1 << (OUTPUT_WIDTH - 1)) - 1;
  localparam int TOP_W     = LUT_AW + 2;
  localparam int TOP_SHIFT = PHASE_WIDTH - TOP_W;

  localparam logic [1:0] MODE_FM = 2'b00;
  localparam logic [1:0] MODE_PM = 2'b01;
  localparam logic [1:0] MODE_CW = 2'b10;

  // Quarter-wave sine magnitudes, entry k = round(AMP*sin(pi/2*k/ROM_DEPTH)).
  // The table never reaches pi/2, so every entry stays at or below AMP.
  function automatic logic [ROM_DEPTH*MAG_W-1:0] build_rom();
    logic [ROM_DEPTH*MAG_W-1:0] rom;
    real ang;
    int  val;
    rom = '0;
    for (int k = 0; k < ROM_DEPTH; k++) begin
      ang = 1.57079632679489661923 * $itor(k) / $itor(ROM_DEPTH);
      val = $rtoi($itor(AMP) * $sin(ang) + 0.5);
      rom[k*MAG_W +: MAG_W] = val[MAG_W-1:0];
    end
    return rom;
  endfunction

  localparam logic [ROM_DEPTH*MAG_W-1:0] ROM = build_rom();

  // Shadow configuration
  logic [1:0]             mode_r;
  logic [PHASE_WIDTH-1:0] center_r;
  logic [DEV_W-1:0]       dev_r;
  logic [PHASE_WIDTH-1:0] off_r;

  // Pipeline state
  logic [INPUT_WIDTH-1:0] hold;
  logic [PHASE_WIDTH-1:0] prod_r;
  logic [PHASE_WIDTH-1:0] pm_d1;
  logic [PHASE_WIDTH-1:0] pm_d2;
  logic [PHASE_WIDTH-1:0] fword_r;
  logic [PHASE_WIDTH-1:0] acc;
  logic [TOP_W-1:0]       ph_top_r;
  logic                   neg_r;
  logic [MAG_W-1:0]       mag_r;
  logic [2:0]             fill_cnt;

  // Combinational helpers
  logic                   is_fm;
  logic                   is_pm;
  logic [PHASE_WIDTH-1:0] hold_x;
  logic [PHASE_WIDTH-1:0] dev_x;
  logic [PHASE_WIDTH-1:0] prod_next;
  logic [PHASE_WIDTH-1:0] pm_term;
  logic [LUT_AW-1:0]      rom_idx;

  // Mode decode, the wrapped product, the PM phase term and the mirrored ROM index
  always_comb begin
    is_fm     = (mode_r == MODE_FM);
    is_pm     = (mode_r == MODE_PM);
    hold_x    = PHASE_WIDTH'($signed(hold));
    dev_x     = PHASE_WIDTH'(dev_r);
    prod_next = hold_x * dev_x;
    pm_term   = is_pm ? (pm_d2 << PM_SHIFT) : '0;
    rom_idx   = ph_top_r[LUT_AW-1:0] ^ {LUT_AW{ph_top_r[LUT_AW]}};
  end

  // Atomic capture of all configuration fields, independent of en
  always_ff @(posedge clk) begin
    if (RST) begin
      mode_r   <= MODE_CW;
      center_r <= '0;
      dev_r    <= '0;
      off_r    <= '0;
    end else if (cfg_load) begin
      mode_r   <= cfg_mode;
      center_r <= cfg_center;
      dev_r    <= cfg_dev;
      off_r    <= cfg_phase_off;
    end
  end

  // S0: sample-and-hold of the baseband input on each strobe
  always_ff @(posedge clk) begin
    if (RST) begin
      hold <= '0;
    end else if (in_valid) begin
      hold <= wave_in;
    end
  end

  // S1..S6: product, tuning word, accumulator, phase, ROM lookup and sign
  always_ff @(posedge clk) begin
    if (RST) begin
      prod_r   <= '0;
      pm_d1    <= '0;
      pm_d2    <= '0;
      fword_r  <= '0;
      acc      <= '0;
      ph_top_r <= '0;
      neg_r    <= 1'b0;
      mag_r    <= '0;
      wave_out <= '0;
    end else if (en) begin
      prod_r   <= prod_next;
      pm_d1    <= prod_r;
      pm_d2    <= pm_d1;
      fword_r  <= is_fm ? (center_r + prod_r) : center_r;
      acc      <= phase_clr ? '0 : (acc + fword_r);
      ph_top_r <= TOP_W'((acc + off_r + pm_term) >> TOP_SHIFT);
      neg_r    <= ph_top_r[LUT_AW+1];
      mag_r    <= ROM[rom_idx*MAG_W +: MAG_W];
      wave_out <= neg_r ? (~{1'b0, mag_r} + 1'b1) : {1'b0, mag_r};
    end
  end

  // Fill tracking: out_valid rises after six enabled cycles and then stays high
  always_ff @(posedge clk) begin
    if (RST) begin
      fill_cnt  <= '0;
      out_valid <= 1'b0;
    end else if (en && !out_valid) begin
      if (fill_cnt == 3'd5) begin
        out_valid <= 1'b1;
      end
      fill_cnt <= fill_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_angle_modulate_ms.sv
// tb_angle_modulate_ms: directed tests for the FM / PM / CW angle modulator.
module tb_angle_modulate_ms;

  localparam int IW = 12;
  localparam int PW = 32;
  localparam int OW = 12;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          RST;
  logic          en;
  logic          in_valid;
  logic [IW-1:0] wave_in;
  logic          cfg_load;
  logic [1:0]    cfg_mode;
  logic [PW-1:0] cfg_center;
  logic [PW-IW-1:0] cfg_dev;
  logic [PW-1:0] cfg_phase_off;
  logic          phase_clr;
  logic [OW-1:0] wave_out;
  logic          out_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  // CW pattern for a quarter-cycle tuning word: 0, +peak, 0, -peak
  logic signed [OW-1:0] pat [4];

  angle_modulate_ms #(
    .INPUT_WIDTH (IW),
    .PHASE_WIDTH (PW),
    .OUTPUT_WIDTH(OW),
    .LUT_AW      (AW),
    .PM_SHIFT    (0)
  ) dut (
    .clk          (clk),
    .RST          (RST),
    .en           (en),
    .in_valid     (in_valid),
    .wave_in      (wave_in),
    .cfg_load     (cfg_load),
    .cfg_mode     (cfg_mode),
    .cfg_center   (cfg_center),
    .cfg_dev      (cfg_dev),
    .cfg_phase_off(cfg_phase_off),
    .phase_clr    (phase_clr),
    .wave_out     (wave_out),
    .out_valid    (out_valid)
  );

  // Clock: 10 time-unit period
  always #5 clk = ~clk;

  // One active edge, then settle before sampling or driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load a config, then clear the accumulator two edges later so that the new tuning word is in place
  task automatic load_and_clear(input logic [1:0] mode, input logic [PW-1:0] center,
                                input logic [PW-IW-1:0] dev);
    cfg_mode = mode; cfg_center = center; cfg_dev = dev; cfg_phase_off = '0;
    cfg_load = 1'b1;
    step();                 // E0
    cfg_load = 1'b0;
    step();                 // E1
    phase_clr = 1'b1;
    step();                 // E2
    phase_clr = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; en = 1'b0; in_valid = 1'b0; wave_in = '0; cfg_load = 1'b0;
    cfg_mode = 2'b00; cfg_center = '0; cfg_dev = '0; cfg_phase_off = '0; phase_clr = 1'b0;
    step(); step();
    tests_run++;
    if (wave_out !== '0) begin
      tests_failed++; $display("FAIL reset_wave got %0d exp 0", $signed(wave_out));
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid got %b exp 0", out_valid);
    end
    RST = 1'b0; en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      tests_run++;
      if (out_valid !== (i == 6)) begin
        tests_failed++; $display("FAIL fill_valid cycle=%0d got %b exp %b", i, out_valid, (i == 6));
      end
    end
  endtask

  task automatic test_cw();
    load_and_clear(2'b10, 32'h4000_0000, '0);
    for (int m = 3; m <= 12; m++) begin
      step();
      if (m >= 5) begin
        tests_run++;
        if ($signed(wave_out) !== pat[(m-5)%4]) begin
          tests_failed++;
          $display("FAIL cw_wave edge=%0d got %0d exp %0d", m, $signed(wave_out), pat[(m-5)%4]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (100) step();
    RST = 1'b1;
    step();
    tests_run++;
    if (wave_out !== '0) begin
      tests_failed++; $display("FAIL midreset_wave got %0d exp 0", $signed(wave_out));
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_valid got %b exp 0", out_valid);
    end
    RST = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      tests_run++;
      if (out_valid !== (i == 6)) begin
        tests_failed++; $display("FAIL refill_valid cycle=%0d got %b exp %b", i, out_valid, (i == 6));
      end
    end
    tests_run++;
    if (wave_out !== '0) begin
      tests_failed++; $display("FAIL midreset_cfg_default got %0d exp 0", $signed(wave_out));
    end
  endtask

  task automatic test_fm();
    logic [PW-1:0] a_prev, a, a1, a2, a3;
    logic [PW-1:0] exp_up, exp_dn;
    exp_up = PW'(32'd268435456 + 32'd1000);
    exp_dn = PW'(32'd268435456 - 32'd1000);
    cfg_mode = 2'b00; cfg_center = 32'h1000_0000; cfg_dev = 20'd1; cfg_phase_off = '0;
    cfg_load = 1'b1; wave_in = IW'(1000); in_valid = 1'b1;
    step();
    cfg_load = 1'b0; in_valid = 1'b0;
    repeat (5) step();
    a_prev = dut.acc;
    for (int i = 0; i < 3; i++) begin
      step();
      a = dut.acc;
      tests_run++;
      if (a - a_prev !== exp_up) begin
        tests_failed++; $display("FAIL fm_step_pos i=%0d got %0d exp %0d", i, a - a_prev, exp_up);
      end
      a_prev = a;
    end
    wave_in = IW'(-1000); in_valid = 1'b1;
    step();                 // strobe edge S
    in_valid = 1'b0;
    step(); a1 = dut.acc;   // S+1
    step(); a2 = dut.acc;   // S+2
    step(); a3 = dut.acc;   // S+3
    tests_run++;
    if (a2 - a1 !== exp_up) begin
      tests_failed++; $display("FAIL fm_step_before got %0d exp %0d", a2 - a1, exp_up);
    end
    tests_run++;
    if (a3 - a2 !== exp_dn) begin
      tests_failed++; $display("FAIL fm_step_after got %0d exp %0d", a3 - a2, exp_dn);
    end
  endtask

  task automatic test_pm();
    int smp  [12];
    int expv [12];
    smp  = '{0, 1024, 0, -1024, 0, 1024, 0, -1024, 0, 1024, 0, -1024};
    expv = '{0, 783,  0, -772,  0, 783,  0, -772,  0, 783,  0, -772};
    load_and_clear(2'b01, '0, 20'h4_0000);
    for (int j = 0; j < 18; j++) begin
      if (j < 12) begin
        wave_in = IW'(smp[j]); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (j >= 6) begin
        tests_run++;
        if (int'($signed(wave_out)) !== expv[j-6]) begin
          tests_failed++;
          $display("FAIL pm_wave sample=%0d got %0d exp %0d", j - 6, $signed(wave_out), expv[j-6]);
        end
      end
    end
  endtask

  task automatic test_cfg_switch();
    logic [PW-1:0] a_prev, a;
    logic [PW-1:0] exp_step [5];
    exp_step = '{32'h0400_0000, 32'h0400_0000, 32'h0800_0000 + 32'd500,
                 32'h0800_0000 + 32'd500, 32'h0800_0000 + 32'd500};
    cfg_mode = 2'b10; cfg_center = 32'h0400_0000; cfg_dev = 20'd5; cfg_phase_off = '0;
    cfg_load = 1'b1; wave_in = IW'(100); in_valid = 1'b1;
    step();
    cfg_load = 1'b0; in_valid = 1'b0;
    repeat (4) step();
    a_prev = dut.acc;
    cfg_mode = 2'b00; cfg_center = 32'h0800_0000; cfg_dev = 20'd5;
    cfg_load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      cfg_load = 1'b0;
      a = dut.acc;
      tests_run++;
      if (a - a_prev !== exp_step[i]) begin
        tests_failed++; $display("FAIL switch_step i=%0d got %0d exp %0d", i, a - a_prev, exp_step[i]);
      end
      tests_run++;
      if (out_valid !== 1'b1) begin
        tests_failed++; $display("FAIL switch_valid i=%0d got %b exp 1", i, out_valid);
      end
      a_prev = a;
    end
  endtask

  task automatic test_en_freeze();
    load_and_clear(2'b11, 32'h4000_0000, '0);
    for (int m = 3; m <= 12; m++) begin
      step();
      if (m >= 9) begin
        tests_run++;
        if ($signed(wave_out) !== pat[(m-5)%4]) begin
          tests_failed++;
          $display("FAIL pre_freeze edge=%0d got %0d exp %0d", m, $signed(wave_out), pat[(m-5)%4]);
        end
      end
    end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      phase_clr = (k == 3);
      in_valid  = (k == 5);
      wave_in   = IW'(77);
      step();
      tests_run++;
      if ($signed(wave_out) !== pat[3] || out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL freeze_hold k=%0d got %0d/%b exp %0d/1", k, $signed(wave_out), out_valid, pat[3]);
      end
    end
    phase_clr = 1'b0; in_valid = 1'b0; en = 1'b1;
    for (int m = 13; m <= 20; m++) begin
      step();
      tests_run++;
      if ($signed(wave_out) !== pat[(m-5)%4]) begin
        tests_failed++;
        $display("FAIL post_freeze edge=%0d got %0d exp %0d", m, $signed(wave_out), pat[(m-5)%4]);
      end
    end
  endtask

  initial begin
    pat[0] = 12'sd0;
    pat[1] = 12'sd2047;
    pat[2] = 12'sd0;
    pat[3] = -12'sd2047;
    test_reset();
    test_cw();
    test_reset_mid();
    test_fm();
    test_pm();
    test_cfg_switch();
    test_en_freeze();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
